// File: rtl/sync_fwft_blkram_fifo.sv
// sync_fwft_blkram_fifo
//   Single-clock FIFO on an inferred dual-port block RAM with registered reads,
//   presenting a first-word-fall-through head word (o/valid) fed by a prefetch
//   pipeline of 1+REGRAM RAM read stages plus the output holding register.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   d, we      write data / write request (accepted when we && !full)
//   full       no write accepted this cycle (count == DEPTH)
//   afull      count >= AFULL_THRESH
//   o, valid   head-of-FIFO word / o holds the oldest unread word
//   re         pop request (accepted when re && valid)
//   aempty     count <= AEMPTY_THRESH
//   count      words accepted and not yet popped, including prefetched words
//   overflow   one-cycle pulse after a write attempted while full
//   underflow  one-cycle pulse after a pop attempted while !valid
module sync_fwft_blkram_fifo #(
  parameter int D_WIDTH       = 32,
  parameter int ADDR_WIDTH    = 9,
  parameter int REGRAM        = 0,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [D_WIDTH-1:0]    d,
  input  logic                  we,
  output logic                  full,
  output logic                  afull,
  output logic [D_WIDTH-1:0]    o,
  output logic                  valid,
  input  logic                  re,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  logic [D_WIDTH-1:0]  mem [DEPTH];

  // Pointers carry one extra bit so wptr - rptr gives the number of words
  // still sitting in the RAM (not yet read into the prefetch pipeline).
  logic [ADDR_WIDTH:0] wptr, rptr, ram_cnt, count_nxt;
  logic                wr_acc, pop, out_free, s1_free, rd_en;

  // Stage 1: RAM registered read data.
  logic                v1;
  logic [D_WIDTH-1:0]  q1;

  // Last stage ahead of the output register (stage 1, or stage 2 if REGRAM).
  logic                pv;
  logic [D_WIDTH-1:0]  pq;

  always_comb begin
    wr_acc    = we && !full;
    pop       = re && valid;
    // Output register can take a new word when empty or being popped.
    out_free  = !valid || re;
    ram_cnt   = wptr - rptr;
    rd_en     = !rst && (ram_cnt != '0) && s1_free;
    count_nxt = count;
    if (wr_acc && !pop)
      count_nxt = count + ONE;
    else if (pop && !wr_acc)
      count_nxt = count - ONE;
  end

  // Each stage is free when empty or when it is being drained this cycle,
  // so the chain advances in lock-step and sustains one word per cycle.
  if (REGRAM != 0) begin : g_regram
    logic               v2;
    logic [D_WIDTH-1:0] q2;
    logic               s2_free;

    always_comb begin
      s2_free = !v2 || out_free;
      s1_free = !v1 || s2_free;
      pv      = v2;
      pq      = q2;
    end

    always_ff @(posedge clk) begin
      if (rst)
        v2 <= 1'b0;
      else if (s2_free)
        v2 <= v1;
      if (!rst && s2_free && v1)
        q2 <= q1;
    end
  end else begin : g_noregram
    always_comb begin
      s1_free = !v1 || out_free;
      pv      = v1;
      pq      = q1;
    end
  end

  // RAM: no reset on contents or read register, keeps block-RAM inference.
  // Reads only target committed words, so no read-during-write collision.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc)
      mem[wptr[ADDR_WIDTH-1:0]] <= d;
    if (rd_en)
      q1 <= mem[rptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst && pv && out_free)
      o <= pq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      v1        <= 1'b0;
      valid     <= 1'b0;
      count     <= '0;
      full      <= 1'b0;
      afull     <= (AFULL_THRESH == 0);
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)
        wptr <= wptr + ONE;
      if (rd_en)
        rptr <= rptr + ONE;
      if (s1_free)
        v1 <= rd_en;
      if (out_free)
        valid <= pv;
      count     <= count_nxt;
      full      <= (count_nxt == DEPTH_C);
      afull     <= (count_nxt >= AF_C);
      aempty    <= (count_nxt <= AE_C);
      overflow  <= we && full;
      underflow <= re && !valid;
    end
  end

endmodule

// File: tb/tb_sync_fwft_blkram_fifo.sv
// Bench for sync_fwft_blkram_fifo: two instances (REGRAM=0 and REGRAM=1)
// share stimulus; each is tracked by a queue model in which a word becomes
// the visible head LAT cycles after its write edge.
module tb_sync_fwft_blkram_fifo;

  localparam int DEPTH = 512;
  localparam int AFT   = DEPTH - 4;
  localparam int AET   = 4;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [31:0] d;

  logic [31:0] o_w       [2];
  logic        valid_w   [2];
  logic        full_w    [2];
  logic        afull_w   [2];
  logic        aempty_w  [2];
  logic        ovf_w     [2];
  logic        unf_w     [2];
  logic [9:0]  count_w   [2];

  sync_fwft_blkram_fifo #(.D_WIDTH(32), .ADDR_WIDTH(9), .REGRAM(0),
                          .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)) dut0 (
    .clk(clk), .rst(rst), .d(d), .we(we), .full(full_w[0]), .afull(afull_w[0]),
    .o(o_w[0]), .valid(valid_w[0]), .re(re), .aempty(aempty_w[0]),
    .count(count_w[0]), .overflow(ovf_w[0]), .underflow(unf_w[0]));

  sync_fwft_blkram_fifo #(.D_WIDTH(32), .ADDR_WIDTH(9), .REGRAM(1),
                          .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)) dut1 (
    .clk(clk), .rst(rst), .d(d), .we(we), .full(full_w[1]), .afull(afull_w[1]),
    .o(o_w[1]), .valid(valid_w[1]), .re(re), .aempty(aempty_w[1]),
    .count(count_w[1]), .overflow(ovf_w[1]), .underflow(unf_w[1]));

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;

  // Reference model: stored words with their write edge index.
  logic [31:0] md [2][$];
  int          ma [2][$];
  logic        e_ov [2];
  logic        e_un [2];

  function automatic int lat(input int i);
    return 2 + i;
  endfunction

  function automatic logic exp_valid(input int i);
    return (md[i].size() > 0) && (cyc >= ma[i][0] + lat(i));
  endfunction

  // Advance one edge: update the model with the inputs seen at that edge,
  // then compare every output of both instances against it.
  task automatic tick();
    logic vpre, fpre, ev;
    logic [9:0] ecnt;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        md[i].delete();
        ma[i].delete();
        e_ov[i] = 1'b0;
        e_un[i] = 1'b0;
      end else begin
        fpre = (md[i].size() == DEPTH);
        vpre = (md[i].size() > 0) && ((cyc - 1) >= ma[i][0] + lat(i));
        e_ov[i] = we && fpre;
        e_un[i] = re && !vpre;
        if (re && vpre) begin
          void'(md[i].pop_front());
          void'(ma[i].pop_front());
        end
        if (we && !fpre) begin
          md[i].push_back(d);
          ma[i].push_back(cyc);
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      ev   = exp_valid(i);
      ecnt = 10'(md[i].size());
      vectors++;
      if (valid_w[i] !== ev) begin
        errors++;
        $display("FAIL valid dut%0d cyc %0d: got %b want %b", i, cyc, valid_w[i], ev);
      end
      if (ev) begin
        vectors++;
        if (o_w[i] !== md[i][0]) begin
          errors++;
          $display("FAIL o dut%0d cyc %0d: got %h want %h", i, cyc, o_w[i], md[i][0]);
        end
      end
      vectors++;
      if (count_w[i] !== ecnt) begin
        errors++;
        $display("FAIL count dut%0d cyc %0d: got %0d want %0d", i, cyc, count_w[i], ecnt);
      end
      vectors++;
      if ({full_w[i], afull_w[i], aempty_w[i]} !==
          {ecnt == 10'(DEPTH), ecnt >= 10'(AFT), ecnt <= 10'(AET)}) begin
        errors++;
        $display("FAIL flags dut%0d cyc %0d: got full/afull/aempty %b%b%b count %0d",
                 i, cyc, full_w[i], afull_w[i], aempty_w[i], ecnt);
      end
      vectors++;
      if ({ovf_w[i], unf_w[i]} !== {e_ov[i], e_un[i]}) begin
        errors++;
        $display("FAIL errpulse dut%0d cyc %0d: got ovf/unf %b%b want %b%b",
                 i, cyc, ovf_w[i], unf_w[i], e_ov[i], e_un[i]);
      end
    end
  endtask

  task automatic idle(input int n);
    we = 1'b0;
    re = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; re = 1'b1; d = 32'hDEAD_BEEF;
    tick();
    tick();
    rst = 1'b0; we = 1'b0; re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({valid_w[i], full_w[i], afull_w[i], aempty_w[i], ovf_w[i], unf_w[i]} !== 6'b000100
          || count_w[i] !== 10'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got v/f/af/ae/ov/un %b%b%b%b%b%b count %0d want 000100 count 0",
                 i, valid_w[i], full_w[i], afull_w[i], aempty_w[i], ovf_w[i], unf_w[i], count_w[i]);
      end
    end
  endtask

  task automatic test_latency();
    int seen [2];
    we = 1'b1; d = 32'h11;
    tick();
    we = 1'b0;
    seen[0] = -1; seen[1] = -1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (valid_w[i] === 1'b1 && seen[i] < 0) seen[i] = k;
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (seen[i] != 2 + i || o_w[i] !== 32'h11 || count_w[i] !== 10'd1) begin
        errors++;
        $display("FAIL latency dut%0d: valid after %0d edges o %h count %0d want %0d edges o 11 count 1",
                 i, seen[i], o_w[i], count_w[i], 2 + i);
      end
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    idle(2);
  endtask

  task automatic test_fill_overflow();
    for (int k = 0; k < DEPTH; k++) begin
      we = 1'b1; d = 32'(k);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (full_w[i] !== 1'b1 || count_w[i] !== 10'd512 || afull_w[i] !== 1'b1) begin
        errors++;
        $display("FAIL fill dut%0d: full %b afull %b count %0d want 1 1 512",
                 i, full_w[i], afull_w[i], count_w[i]);
      end
    end
    d = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (ovf_w[i] !== 1'b1 || count_w[i] !== 10'd512) begin
        errors++;
        $display("FAIL overflow dut%0d: ovf %b count %0d want 1 512", i, ovf_w[i], count_w[i]);
      end
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (ovf_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL overflow_pulse dut%0d: ovf %b want 0", i, ovf_w[i]);
      end
    end
  endtask

  task automatic test_drain();
    int budget = 0;
    re = 1'b1;
    while ((md[0].size() > 0 || md[1].size() > 0) && budget < 700) begin
      tick();
      budget++;
    end
    if (budget >= 700) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d words left", md[0].size(), md[1].size());
    end
    tick();
    re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (valid_w[i] !== 1'b0 || count_w[i] !== 10'd0 || aempty_w[i] !== 1'b1) begin
        errors++;
        $display("FAIL drain_end dut%0d: valid %b count %0d aempty %b want 0 0 1",
                 i, valid_w[i], count_w[i], aempty_w[i]);
      end
    end
  endtask

  task automatic test_underflow_full_pop();
    re = 1'b1;
    tick();
    re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (unf_w[i] !== 1'b1 || count_w[i] !== 10'd0) begin
        errors++;
        $display("FAIL underflow dut%0d: unf %b count %0d want 1 0", i, unf_w[i], count_w[i]);
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      we = 1'b1; d = $urandom;
      tick();
    end
    idle(4);
    we = 1'b1; re = 1'b1; d = 32'hCAFE_0001;
    tick();
    we = 1'b0; re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (ovf_w[i] !== 1'b1 || count_w[i] !== 10'd511) begin
        errors++;
        $display("FAIL full_pop dut%0d: ovf %b count %0d want 1 511", i, ovf_w[i], count_w[i]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 100; k++) begin
      we = 1'b1; d = 32'(k);
      tick();
    end
    idle(4);
    for (int k = 100; k < 1100; k++) begin
      we = 1'b1; re = 1'b1; d = 32'(k);
      tick();
    end
    we = 1'b0; re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (count_w[i] !== 10'd100 || o_w[i] !== 32'd1000) begin
        errors++;
        $display("FAIL steady dut%0d: count %0d o %0d want 100 1000", i, count_w[i], o_w[i]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 37; k++) begin
      we = 1'b1; d = $urandom;
      tick();
    end
    idle(3);
    rst = 1'b1; we = 1'b1; re = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0; re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (count_w[i] !== 10'd0 || valid_w[i] !== 1'b0 || aempty_w[i] !== 1'b1) begin
        errors++;
        $display("FAIL midreset dut%0d: count %0d valid %b aempty %b want 0 0 1",
                 i, count_w[i], valid_w[i], aempty_w[i]);
      end
    end
    we = 1'b1; d = 32'hA5;
    tick();
    idle(4);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (valid_w[i] !== 1'b1 || o_w[i] !== 32'hA5) begin
        errors++;
        $display("FAIL midreset_refill dut%0d: valid %b o %h want 1 a5", i, valid_w[i], o_w[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 599) == 0);
      we  = ($urandom_range(0, 99) < ((k / 500) % 2 == 0 ? 70 : 35));
      re  = ($urandom_range(0, 99) < 50);
      d   = $urandom;
      tick();
    end
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; d = '0;
    test_reset();
    test_latency();
    test_fill_overflow();
    test_drain();
    test_underflow_full_pop();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
